// File: rtl/noc_axi4_mc_throttle.sv
// AR/AW skid buffering with outstanding-burst caps and DDR4 calibration
// gating between the NoC AXI4 bridge and the MIG slave port (mc_clk).
module noc_axi4_mc_throttle_chan #(
    parameter int W   = 8,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    input  logic         done_i,
    output logic [7:0]   out_o,
    output logic         err_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q, cnt_d;
    logic [7:0]   out_q, out_d;
    logic         err_q, err_d;
    logic         push;
    logic         pop;

    assign s_ready_o = en_i && (cnt_q != 2'd2) && (out_q < 8'(MAX));
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign push      = s_valid_i && s_ready_o;
    assign pop       = m_valid_o && m_ready_i;
    assign out_o     = out_q;
    assign err_o     = err_q;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        err_d = err_q;
        out_d = out_q + {7'd0, push} - {7'd0, done_i};
        // a response with nothing outstanding is flagged and never wraps
        if (done_i && (out_q == 8'd0)) begin
            err_d = 1'b1;
            out_d = {7'd0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            out_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data_i;
    end
endmodule

module noc_axi4_mc_throttle #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 35,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_RD_OUT = 8,
    parameter int MAX_WR_OUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    phy_init_done,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [7:0]              rd_outstanding,
    output logic [7:0]              wr_outstanding,
    output logic                    cnt_err
);
    localparam int AW = ID_WIDTH + ADDR_WIDTH + 13;

    logic          en;
    logic [AW-1:0] ar_s, ar_m, aw_s, aw_m;
    logic          rd_done, wr_done;
    logic          rd_err, wr_err;

    assign en = phy_init_done && !rst;

    assign ar_s = {s_axi_arid, s_axi_araddr, s_axi_arlen,
                   s_axi_arsize, s_axi_arburst};
    assign aw_s = {s_axi_awid, s_axi_awaddr, s_axi_awlen,
                   s_axi_awsize, s_axi_awburst};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen,
            m_axi_arsize, m_axi_arburst} = ar_m;
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen,
            m_axi_awsize, m_axi_awburst} = aw_m;

    // a read burst resolves on its last beat, a write on its response
    assign rd_done = m_axi_rvalid && s_axi_rready && m_axi_rlast;
    assign wr_done = m_axi_bvalid && s_axi_bready;

    noc_axi4_mc_throttle_chan #(.W(AW), .MAX(MAX_RD_OUT)) u_ar (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .s_data_i (ar_s),
        .s_valid_i(s_axi_arvalid),
        .s_ready_o(s_axi_arready),
        .m_data_o (ar_m),
        .m_valid_o(m_axi_arvalid),
        .m_ready_i(m_axi_arready),
        .done_i   (rd_done),
        .out_o    (rd_outstanding),
        .err_o    (rd_err)
    );

    noc_axi4_mc_throttle_chan #(.W(AW), .MAX(MAX_WR_OUT)) u_aw (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .s_data_i (aw_s),
        .s_valid_i(s_axi_awvalid),
        .s_ready_o(s_axi_awready),
        .m_data_o (aw_m),
        .m_valid_o(m_axi_awvalid),
        .m_ready_i(m_axi_awready),
        .done_i   (wr_done),
        .out_o    (wr_outstanding),
        .err_o    (wr_err)
    );

    assign cnt_err = rd_err || wr_err;

    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wvalid = s_axi_wvalid && phy_init_done;
    assign s_axi_wready = m_axi_wready && en;

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
endmodule
